// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the LEGv8 instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned FETCH_N           = 32;
    localparam int unsigned FETCH_AW          = 7;
    localparam int unsigned FETCH_PCW         = 64;
    localparam int unsigned FETCH_DEPTH       = 4;
    localparam int unsigned FETCH_DBG_MAXWAIT = 7;

    typedef enum logic {
        RUN,
        END
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_N-1:0]   instr;
        logic [FETCH_PCW-1:0] pc;
    } fetch_entry_t;

    // True when a byte PC addresses a word inside a ROM of 2^aw words.
    function automatic logic pc_in_rom(input logic [FETCH_PCW-1:0] pc, input int unsigned aw);
        return (pc >> (aw + 32'd2)) == '0;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch queue of {instr, pc} entries; flush overrides push.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = FETCH_DEPTH,
    localparam int unsigned PTRW  = $clog2(DEPTH),
    localparam int unsigned CNTW  = PTRW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  fetch_entry_t    entry_i,
    output fetch_entry_t    head_o,
    output logic [CNTW-1:0] count_o
);

    fetch_entry_t    mem_q [DEPTH];
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            do_pop;
    logic            do_push;

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q < CNTW'(DEPTH)) || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTRW'(1);
            if (do_push) wr_ptr_d = wr_ptr_q + PTRW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNTW'(1);
                2'b01:   count_d = count_q - CNTW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: shares the instruction ROM port between the IF prefetch
// stream and debug readback, and tracks PC, redirects and end-of-ROM.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned AW          = FETCH_AW,
    parameter int unsigned DEPTH       = FETCH_DEPTH,
    parameter int unsigned DBG_MAXWAIT = FETCH_DBG_MAXWAIT
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [AW-1:0]        imem_addr,
    input  logic [FETCH_N-1:0]   imem_q,
    input  logic                 stall_i,
    input  logic                 redirect_i,
    input  logic [FETCH_PCW-1:0] redirect_pc,
    output logic                 valid_o,
    output logic [FETCH_N-1:0]   instr_o,
    output logic [FETCH_PCW-1:0] pc_o,
    input  logic                 dbg_req,
    input  logic [AW-1:0]        dbg_addr,
    output logic                 dbg_ack,
    output logic [FETCH_N-1:0]   dbg_data
);

    localparam int unsigned CNTW = $clog2(DEPTH) + 1;
    localparam int unsigned WCW  = $clog2(DBG_MAXWAIT + 1);

    fetch_state_t         state_q, state_d;
    logic [FETCH_PCW-1:0] fetch_pc_q, fetch_pc_d;
    logic [WCW-1:0]       wait_cnt_q, wait_cnt_d;
    logic                 dbg_ack_q, dbg_ack_d;
    logic [FETCH_N-1:0]   dbg_data_q, dbg_data_d;

    logic [CNTW-1:0]      count;
    fetch_entry_t         head;
    fetch_entry_t         entry;
    logic                 pop;
    logic                 push;
    logic                 grant;
    logic [FETCH_PCW-1:0] next_pc;
    logic [FETCH_PCW-1:0] redir_pc;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .entry_i (entry),
        .head_o  (head),
        .count_o (count)
    );

    // Port arbitration and enqueue decision for the current cycle.
    always_comb begin
        pop      = (count != '0) && !stall_i;
        grant    = dbg_req && !redirect_i && !dbg_ack_q &&
                   ((count >= CNTW'(2)) || (state_q == END) ||
                    (wait_cnt_q == WCW'(DBG_MAXWAIT)));
        push     = (state_q == RUN) && !redirect_i && !grant &&
                   ((count < CNTW'(DEPTH)) || pop);
        imem_addr = grant ? dbg_addr : fetch_pc_q[AW+1:2];
        next_pc  = fetch_pc_q + FETCH_PCW'(4);
        redir_pc = redirect_pc & ~FETCH_PCW'(3);
        entry    = '{instr: imem_q, pc: fetch_pc_q};
    end

    // Next-state for PC, fetch state and debug handshake.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        wait_cnt_d = wait_cnt_q;
        dbg_ack_d  = grant;
        dbg_data_d = dbg_data_q;

        if (redirect_i) begin
            fetch_pc_d = redir_pc;
            state_d    = pc_in_rom(redir_pc, AW) ? RUN : END;
        end else if (push) begin
            fetch_pc_d = next_pc;
            if (!pc_in_rom(next_pc, AW)) state_d = END;
        end

        if (grant) dbg_data_d = imem_q;

        if (!dbg_req || grant) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WCW'(DBG_MAXWAIT)) begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            fetch_pc_q <= '0;
            wait_cnt_q <= '0;
            dbg_ack_q  <= 1'b0;
            dbg_data_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            wait_cnt_q <= wait_cnt_d;
            dbg_ack_q  <= dbg_ack_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    assign valid_o  = (count != '0);
    assign instr_o  = head.instr;
    assign pc_o     = head.pc;
    assign dbg_ack  = dbg_ack_q;
    assign dbg_data = dbg_data_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: a pc scoreboard checks every
// instruction popped by IF; scenario tasks check timing and debug handshakes.
module tb_imem_fetch_ctrl;
    import fetch_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [FETCH_AW-1:0]  imem_addr;
    logic [FETCH_N-1:0]   imem_q;
    logic                 stall_i = 1'b0;
    logic                 redirect_i = 1'b0;
    logic [FETCH_PCW-1:0] redirect_pc = '0;
    logic                 valid_o;
    logic [FETCH_N-1:0]   instr_o;
    logic [FETCH_PCW-1:0] pc_o;
    logic                 dbg_req = 1'b0;
    logic [FETCH_AW-1:0]  dbg_addr = '0;
    logic                 dbg_ack;
    logic [FETCH_N-1:0]   dbg_data;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_pc;
    logic [31:0] mon_instr;

    imem_fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_q      (imem_q),
        .stall_i     (stall_i),
        .redirect_i  (redirect_i),
        .redirect_pc (redirect_pc),
        .valid_o     (valid_o),
        .instr_o     (instr_o),
        .pc_o        (pc_o),
        .dbg_req     (dbg_req),
        .dbg_addr    (dbg_addr),
        .dbg_ack     (dbg_ack),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    // ROM model: word k holds 0x1000_0000 + k.
    assign imem_q = 32'h1000_0000 + 32'(imem_addr);

    // Scoreboard: every IF pop must match the next expected pc and its ROM word.
    always @(negedge clk) begin
        if (!reset && valid_o && !stall_i) begin
            pops++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected pc_o=%h instr_o=%h required no pop", pc_o, instr_o);
            end else begin
                mon_pc    = exp_q.pop_front();
                mon_instr = 32'h1000_0000 + 32'(mon_pc >> 2);
                if (pc_o !== mon_pc || instr_o !== mon_instr) begin
                    failures++;
                    $display("FAIL pop_data pc_o=%h instr_o=%h required pc=%h instr=%h",
                             pc_o, instr_o, mon_pc, mon_instr);
                end
            end
        end
    end

    task automatic stream_expect(input logic [63:0] start, input int n);
        logic [63:0] pc;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            pc = start + 64'(4 * i);
            if (pc >= 64'h200) break;
            exp_q.push_back(pc);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; dbg_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        pops = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (valid_o !== 1'b0 || instr_o !== '0 || pc_o !== '0) begin
            failures++;
            $display("FAIL reset_head valid=%b instr=%h pc=%h required 0/0/0", valid_o, instr_o, pc_o);
        end
        checks++;
        if (dbg_ack !== 1'b0 || dbg_data !== '0) begin
            failures++;
            $display("FAIL reset_dbg ack=%b data=%h required 0/0", dbg_ack, dbg_data);
        end
        checks++;
        if (imem_addr !== '0) begin
            failures++;
            $display("FAIL reset_addr imem_addr=%h required 0", imem_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_streaming();
        int gaps = 0;
        apply_reset();
        stream_expect(64'h0, 64);
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin
            failures++;
            $display("FAIL stream_cycle0 valid_o=%b required 0", valid_o);
        end
        repeat (20) begin
            @(negedge clk);
            if (valid_o !== 1'b1) gaps++;
        end
        @(posedge clk); #1;
        checks++;
        if (gaps != 0 || pops != 20) begin
            failures++;
            $display("FAIL stream_rate gaps=%0d pops=%0d required 0/20", gaps, pops);
        end
    endtask

    task automatic test_stall_full();
        int gaps = 0;
        apply_reset();
        stall_i = 1'b1;
        stream_expect(64'h0, 64);
        repeat (10) begin
            @(posedge clk); #1;
        end
        checks++;
        if (imem_addr !== 7'd4 || valid_o !== 1'b1 || pc_o !== 64'h0) begin
            failures++;
            $display("FAIL stall_full addr=%h valid=%b pc=%h required 4/1/0", imem_addr, valid_o, pc_o);
        end
        stall_i = 1'b0;
        pops = 0;
        repeat (8) begin
            @(negedge clk);
            if (valid_o !== 1'b1) gaps++;
        end
        @(posedge clk); #1;
        checks++;
        if (gaps != 0 || pops != 8) begin
            failures++;
            $display("FAIL stall_release gaps=%0d pops=%0d required 0/8", gaps, pops);
        end
    endtask

    task automatic test_redirect_pop();
        apply_reset();
        stream_expect(64'h0, 64);
        repeat (5) begin
            @(posedge clk); #1;
        end
        redirect_i  = 1'b1;
        redirect_pc = 64'h103;
        @(posedge clk); #1;
        redirect_i = 1'b0;
        stream_expect(64'h100, 64);
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || imem_addr !== 7'h40) begin
            failures++;
            $display("FAIL redirect_flush valid=%b addr=%h required 0/40", valid_o, imem_addr);
        end
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 64'h100 || instr_o !== 32'h1000_0040) begin
            failures++;
            $display("FAIL redirect_first valid=%b pc=%h instr=%h required 1/100/10000040",
                     valid_o, pc_o, instr_o);
        end
    endtask

    task automatic test_end_of_rom();
        apply_reset();
        stream_expect(64'h0, 64);
        repeat (3) begin
            @(posedge clk); #1;
        end
        redirect_i  = 1'b1;
        redirect_pc = 64'h1F8;
        @(posedge clk); #1;
        redirect_i = 1'b0;
        stream_expect(64'h1F8, 64);
        pops = 0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        checks++;
        if (pops != 2 || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL rom_end pops=%0d valid=%b required 2/0", pops, valid_o);
        end
        redirect_i  = 1'b1;
        redirect_pc = 64'h0;
        @(posedge clk); #1;
        redirect_i = 1'b0;
        stream_expect(64'h0, 64);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 64'h0) begin
            failures++;
            $display("FAIL rom_resume valid=%b pc=%h required 1/0", valid_o, pc_o);
        end
        redirect_i  = 1'b1;
        redirect_pc = 64'h400;
        @(posedge clk); #1;
        redirect_i = 1'b0;
        exp_q.delete();
        pops = 0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        checks++;
        if (pops != 0 || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL rom_out_of_range pops=%0d valid=%b required 0/0", pops, valid_o);
        end
    endtask

    task automatic test_dbg_full();
        apply_reset();
        stall_i = 1'b1;
        stream_expect(64'h0, 64);
        repeat (6) begin
            @(posedge clk); #1;
        end
        dbg_req  = 1'b1;
        dbg_addr = 7'd5;
        @(negedge clk);
        checks++;
        if (imem_addr !== 7'd5 || dbg_ack !== 1'b0) begin
            failures++;
            $display("FAIL dbg_grant addr=%h ack=%b required 5/0", imem_addr, dbg_ack);
        end
        @(posedge clk); #1;
        checks++;
        if (dbg_ack !== 1'b1 || dbg_data !== 32'h1000_0005) begin
            failures++;
            $display("FAIL dbg_ack ack=%b data=%h required 1/10000005", dbg_ack, dbg_data);
        end
        dbg_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (dbg_ack !== 1'b0) begin
            failures++;
            $display("FAIL dbg_pulse ack=%b required 0", dbg_ack);
        end
        stall_i = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_dbg_wait();
        int n = 0;
        logic got = 1'b0;
        apply_reset();
        stream_expect(64'h0, 64);
        repeat (4) begin
            @(posedge clk); #1;
        end
        dbg_req  = 1'b1;
        dbg_addr = 7'd9;
        while (n < 20 && !got) begin
            @(posedge clk); #1;
            n++;
            if (dbg_ack === 1'b1) got = 1'b1;
        end
        dbg_req = 1'b0;
        checks++;
        if (!got || n != 8) begin
            failures++;
            $display("FAIL dbg_wait_latency got=%b cycles=%0d required 1/8", got, n);
        end
        checks++;
        if (dbg_data !== 32'h1000_0009 || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL dbg_wait_data data=%h valid=%b required 10000009/0", dbg_data, valid_o);
        end
        repeat (5) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        stall_i = 1'b1;
        stream_expect(64'h0, 64);
        repeat (3) begin
            @(posedge clk); #1;
        end
        dbg_req  = 1'b1;
        dbg_addr = 7'd2;
        reset    = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (valid_o !== 1'b0 || dbg_ack !== 1'b0 || dbg_data !== '0) begin
            failures++;
            $display("FAIL reset_mid valid=%b ack=%b data=%h required 0/0/0", valid_o, dbg_ack, dbg_data);
        end
        reset   = 1'b0;
        dbg_req = 1'b0;
        stall_i = 1'b0;
        stream_expect(64'h0, 64);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || pc_o !== 64'h0 || instr_o !== 32'h1000_0000) begin
            failures++;
            $display("FAIL reset_restart valid=%b pc=%h instr=%h required 1/0/10000000",
                     valid_o, pc_o, instr_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_streaming();
        test_stall_full();
        test_redirect_pop();
        test_end_of_rom();
        test_dbg_full();
        test_dbg_wait();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the pipelined LEGv8 core.
- Owns the single read port of the 128-word instruction ROM and shares it between two users: the IF-stage fetch stream and a debug readback port.
- Keeps a small prefetch queue toward IF/ID, and handles stalls, branch redirects and end-of-ROM.
- ROM read is combinational: address in, word out in the same cycle.

Parameters:
- N, 32, instruction width.
- AW, 7, ROM word-address width (128 words).
- PCW, 64, PC width in bytes.
- DEPTH, 4, prefetch queue entries (power of two, at least 2).
- DBG_MAXWAIT, 7, maximum cycles a pending debug request waits before forced grant.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- imem_addr  out  AW  word address to ROM.
- imem_q  in  N  ROM data for imem_addr, same cycle.
- stall_i  in  1  IF/ID cannot accept this cycle.
- redirect_i  in  1  branch taken / flush request.
- redirect_pc  in  PCW  new byte PC.
- valid_o  out  1  instr_o/pc_o hold a valid instruction.
- instr_o  out  N  queue head instruction.
- pc_o  out  PCW  byte PC of queue head.
- dbg_req  in  1  debug read request, level, held until ack.
- dbg_addr  in  AW  debug word address.
- dbg_ack  out  1  one-cycle pulse, dbg_data valid.
- dbg_data  out  N  debug read result.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Reset values: fetch_pc=0, queue count=0, valid_o=0, instr_o=0, pc_o=0, dbg_ack=0, dbg_data=0, wait_cnt=0, state=RUN.
  - Reset mid-operation discards queue contents and any in-flight debug grant.
  - A still-high dbg_req is re-arbitrated from scratch.
- Address mapping:
  - imem_addr = fetch_pc[AW+1:2] when fetch owns the port; dbg_addr when debug owns it.
  - When the port is idle, imem_addr = fetch_pc[AW+1:2]; the value is don't-care to the ROM.
- States:
  - RUN: fetching.
  - END: fetch_pc >= 4*2^AW; no fetch issued.
  - RUN->END when an enqueue advances fetch_pc to 4*2^AW.
  - END->RUN only on redirect_i with an in-range redirect_pc.
  - An out-of-range redirect_pc enters END directly.
- Pop: occurs when valid_o && !stall_i. valid_o = (count != 0). Head outputs come directly from the queue, combinational from registers.
- Fetch enqueue conditions, all required in the same cycle:
  - state=RUN;
  - !redirect_i;
  - fetch owns the port;
  - count<DEPTH, or count==DEPTH with a pop this cycle.
  - On enqueue, store {imem_q, fetch_pc} and set fetch_pc += 4.
- Redirect has highest priority:
  - The queue is flushed (count=0 next cycle) and fetch_pc <= {redirect_pc[PCW-1:2], 2'b00}.
  - There is no enqueue that cycle.
  - A pop in the same cycle is still consumed by IF (valid_o stays combinationally visible); flush wins for the stored state.
  - First fetch at the new PC happens the next cycle, so valid_o rises 2 cycles after redirect.
- Debug grant occurs when dbg_req && !redirect_i && !dbg_ack and one of:
  - count>=2;
  - state=END;
  - wait_cnt==DBG_MAXWAIT.
- On grant: the ROM is read at dbg_addr; dbg_data <= imem_q; dbg_ack=1 the next cycle for exactly one cycle; wait_cnt <= 0.
- Requester behaviour: the requester drops dbg_req in the ack cycle. No grant is made in the ack cycle.
- wait_cnt: increments (saturating at DBG_MAXWAIT) each cycle dbg_req is high without grant; cleared when dbg_req is low.
- Fetch in grant cycles: fetch loses the port, and no enqueue occurs.
- Queue: circular buffer with wrap-around read/write pointers of log2(DEPTH) bits; count is log2(DEPTH)+1 bits. Pointers wrap silently.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {RUN, END};
  - typedef fetch_entry_t struct {instr, pc};
  - localparams for default DEPTH, PCW, AW.
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO with push, pop, flush (flush has priority over push), count, and head outputs.
- imem_fetch_ctrl instantiates fetch_fifo and contains the arbitration and PC logic.

Test Plan:
- Streaming: ROM word k = 32'h1000_0000+k; after reset, no stall, no redirect -> valid_o first high in cycle 1, instr_o sequence 10000000, 10000001, …, pc_o 0, 4, 8, …, one per cycle.
- Stall full: stall_i=1 for 10 cycles -> count saturates at 4, fetch_pc=16; release -> pops 0..3 then 4 with no gap and no duplicate.
- Redirect with pop: redirect_i=1, redirect_pc=0x103 during a pop cycle -> queue empty next cycle; valid_o back 2 cycles after redirect with pc_o=0x100, instr_o=10000040.
- End of ROM: redirect to 0x1F8 -> words 126 and 127 delivered, state END, no further valid_o; redirect to 0 resumes.
- Debug arbitration: dbg_req, dbg_addr=5 while queue full -> dbg_ack next cycle with dbg_data=10000005. With stall_i=0 and count<2 continuously -> grant after exactly 7 wait cycles, with fetch skipping one slot.
- Reset: reset with count=3 and dbg grant in flight -> next cycle valid_o=0 and dbg_ack=0; fetch restarts at pc 0.
